me_operand_loader: RTL and testbench



---
 rtl/me_operand_loader_pkg.sv | 26 ++
 rtl/me_operand_loader_if.sv | 16 +
 rtl/me_operand_loader_limb_buf.sv | 28 ++
 rtl/me_operand_loader.sv | 187 ++++++++++++++++++
 tb/tb_me_operand_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_operand_loader_pkg.sv
// Shared types and sizing helpers for the modular-exponentiation operand loader.
// Loader states are plain localparam codes so that checkers can bind to the exported state.
package me_pkg;

    localparam int ME_K = 128;
    localparam int ME_N = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_LOAD     = 3'd0;
    localparam state_t ST_START    = 3'd1;
    localparam state_t ST_GAP      = 3'd2;
    localparam state_t ST_STREAM   = 3'd3;
    localparam state_t ST_WAIT_RES = 3'd4;

    // Width of a limb index into an N-entry buffer.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the shared beat counter; it must reach 2N-1 while loading.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(2 * n);
    endfunction

endpackage

// File: rtl/me_operand_loader_if.sv
// Host-side limb stream into the operand loader.
// A beat moves on every rising edge where s_valid and s_ready are both high; s_data is held while s_valid waits.
interface me_operand_loader_if
    import me_pkg::*;
#(
    parameter int K = ME_K
);

    logic [K-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/me_operand_loader_limb_buf.sv
// N x K limb register array: one synchronous write port, combinational read by index.
// Contents are not reset; every job rewrites all entries before they are streamed.
module me_limb_buf
    import me_pkg::*;
#(
    parameter int K  = ME_K,
    parameter int N  = ME_N,
    parameter int IW = idx_w(ME_N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [K-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [K-1:0]  rdata
);

    logic [K-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/me_operand_loader.sv
// Operand loader: buffers X then Y from the host, starts the exponentiation core and streams paired limbs.
// Optional WAIT_RES watchdog enabled by defining ME_LOADER_TIMEOUT_EN. N must be at least 2.
module me_operand_loader
    import me_pkg::*;
#(
    parameter int K         = ME_K,
    parameter int N         = ME_N,
    parameter int START_GAP = 10,
    parameter int TIMEOUT   = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    me_operand_loader_if.slave  host,
    output logic                me_start,
    output logic [K-1:0]        me_x,
    output logic                me_x_valid,
    output logic [K-1:0]        me_y,
    output logic                me_y_valid,
    input  logic                me_valid,
    output logic                busy,
    output logic                job_done,
    output logic                err,
    output state_t              state_dbg
);

    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(N);

    localparam logic [CW-1:0] LOAD_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] RES_LAST  = CW'(N - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(START_GAP - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    gap_cnt, gap_cnt_n;
    logic          s_ready_q;
    logic          hs;
    logic          x_we, y_we;
    logic [IW-1:0] waddr, raddr;
    logic [K-1:0]  x_rd, y_rd;
    logic          timeout_hit;

`ifdef ME_LOADER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wd, wd_n;
    logic          err_q;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

    assign host.s_ready = s_ready_q;
    assign state_dbg    = state;
    assign hs           = host.s_valid && s_ready_q;

    // One counter serves as load beat, stream beat and result-cycle counter.
    always_comb begin
        x_we  = hs && (cnt < N_C);
        y_we  = hs && !(cnt < N_C);
        waddr = IW'((cnt < N_C) ? cnt : (cnt - N_C));
        raddr = IW'(cnt_n);
    end

    me_limb_buf #(.K(K), .N(N), .IW(IW)) u_xbuf (
        .clk   (clk),
        .we    (x_we),
        .waddr (waddr),
        .wdata (host.s_data),
        .raddr (raddr),
        .rdata (x_rd)
    );

    me_limb_buf #(.K(K), .N(N), .IW(IW)) u_ybuf (
        .clk   (clk),
        .we    (y_we),
        .waddr (waddr),
        .wdata (host.s_data),
        .raddr (raddr),
        .rdata (y_rd)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        gap_cnt_n   = gap_cnt;
        timeout_hit = 1'b0;
`ifdef ME_LOADER_TIMEOUT_EN
        wd_n        = wd;
`endif
        case (state)
            ST_LOAD: begin
                if (hs) begin
                    if (cnt == LOAD_LAST) begin
                        state_n = ST_START;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            ST_START: begin
                state_n   = ST_GAP;
                gap_cnt_n = '0;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_STREAM;
                    cnt_n   = '0;
                end else begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end
            end
            ST_STREAM: begin
                if (cnt == N_C) begin
                    state_n = ST_WAIT_RES;
                    cnt_n   = '0;
`ifdef ME_LOADER_TIMEOUT_EN
                    wd_n    = '0;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_WAIT_RES: begin
                // cnt stays 0 until the first result beat, then counts result cycles.
`ifdef ME_LOADER_TIMEOUT_EN
                timeout_hit = (cnt == '0) && (wd == WD_LAST);
                if ((cnt == '0) && !me_valid && !timeout_hit) begin
                    wd_n = wd + WW'(1);
                end
`endif
                if (timeout_hit || (cnt == RES_LAST)) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end else if ((cnt != '0) || me_valid) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_LOAD;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            gap_cnt    <= '0;
            s_ready_q  <= 1'b0;
            me_start   <= 1'b0;
            me_x       <= '0;
            me_y       <= '0;
            me_x_valid <= 1'b0;
            me_y_valid <= 1'b0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
`ifdef ME_LOADER_TIMEOUT_EN
            wd         <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gap_cnt    <= gap_cnt_n;
            s_ready_q  <= (state_n == ST_LOAD);
            me_start   <= (state_n == ST_START);
            me_x_valid <= (state_n == ST_STREAM);
            me_y_valid <= (state_n == ST_STREAM);
            me_x       <= ((state_n == ST_STREAM) && (cnt_n < N_C)) ? x_rd : '0;
            me_y       <= ((state_n == ST_STREAM) && (cnt_n < N_C)) ? y_rd : '0;
            busy       <= (state_n != ST_LOAD);
            job_done   <= (state_n == ST_WAIT_RES) && (cnt_n == RES_LAST);
`ifdef ME_LOADER_TIMEOUT_EN
            wd         <= wd_n;
            err_q      <= (state_n == ST_WAIT_RES) && (cnt_n == '0) && (wd_n == WD_LAST);
`endif
        end
    end

endmodule

// File: tb/tb_me_operand_loader.sv
// Bench for me_operand_loader: job-timeline model checked every cycle plus directed stream/result checks.
// Build with ME_LOADER_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT overridden to 100).
module tb_me_operand_loader;
    import me_pkg::*;

    localparam int K  = 128;
    localparam int N  = 32;
    localparam int G  = 10;
    localparam int TO = 100;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         me_valid = 1'b0;
    logic         me_start, me_x_valid, me_y_valid, busy, job_done, err;
    logic [K-1:0] me_x, me_y;
    state_t       state_dbg;

    me_operand_loader_if #(.K(K)) host ();

    me_operand_loader #(.K(K), .N(N), .START_GAP(G), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host),
        .me_start   (me_start),
        .me_x       (me_x),
        .me_x_valid (me_x_valid),
        .me_y       (me_y),
        .me_y_valid (me_y_valid),
        .me_valid   (me_valid),
        .busy       (busy),
        .job_done   (job_done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Job-timeline model: a job is fully described by the cycle of its last host accept
    // and the cycle of the first result beat.
    bit           chk_en   = 1'b0;
    bit           job      = 1'b0;
    int           ld_cnt   = 0;
    int           ready_at = 0;
    int           t_acc    = 0;
    int           first_v  = -1;
    logic [K-1:0] mx [N];
    logic [K-1:0] my [N];
    int           sf, sl, wf;
    logic         e_start, e_val, e_ready, e_busy, e_done, e_err;
    logic [K-1:0] ex, ey;

    always @(negedge clk) begin
        if (chk_en) begin
            e_start = 1'b0; e_val = 1'b0; e_ready = 1'b0; e_busy = 1'b0;
            e_done  = 1'b0; e_err = 1'b0; ex = '0; ey = '0;
            if (job) begin
                sf      = t_acc + 2 + G;
                sl      = sf + N;
                wf      = sl + 1;
                e_busy  = 1'b1;
                e_start = (cyc == t_acc + 1);
                e_val   = (cyc >= sf) && (cyc <= sl);
                if (e_val && (cyc - sf < N)) begin
                    ex = mx[cyc - sf];
                    ey = my[cyc - sf];
                end
                e_done = (first_v >= 0) && (cyc == first_v + N - 1);
`ifdef ME_LOADER_TIMEOUT_EN
                e_err = (first_v < 0) && (cyc == wf + TO - 1);
`endif
            end else begin
                e_ready = (cyc >= ready_at);
            end
            check("s_ready", host.s_ready, e_ready);
            check("me_start", me_start, e_start);
            check("me_x_valid", me_x_valid, e_val);
            check("me_y_valid", me_y_valid, e_val);
            check("me_x", me_x, ex);
            check("me_y", me_y, ey);
            check("busy", busy, e_busy);
            check("job_done", job_done, e_done);
            check("err", err, e_err);
        end
        if (rst) begin
            job      = 1'b0;
            ld_cnt   = 0;
            ready_at = cyc + 2;
            chk_en   = 1'b1;
        end else if (!job) begin
            if ((cyc >= ready_at) && host.s_valid) begin
                if (ld_cnt < N) mx[ld_cnt] = host.s_data;
                else my[ld_cnt - N] = host.s_data;
                ld_cnt++;
                if (ld_cnt == 2 * N) begin
                    job     = 1'b1;
                    t_acc   = cyc;
                    first_v = -1;
                end
            end
        end else begin
            wf = t_acc + 3 + G + N;
`ifdef ME_LOADER_TIMEOUT_EN
            if ((first_v < 0) && (cyc == wf + TO - 1)) begin
                job      = 1'b0;
                ld_cnt   = 0;
                ready_at = cyc + 1;
            end else
`endif
            if ((first_v < 0) && (cyc >= wf) && me_valid) begin
                first_v = cyc;
            end else if ((first_v >= 0) && (cyc == first_v + N - 1)) begin
                job      = 1'b0;
                ld_cnt   = 0;
                ready_at = cyc + 1;
            end
        end
        cyc++;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input int xb, input int yb, input bit bp);
        int  sent   = 0;
        int  budget = 0;
        bit  acc;
        while ((sent < 2 * N) && (budget < 2000)) begin
            if (bp && (budget % 2 == 1)) begin
                host.s_valid = 1'b0;
            end else begin
                host.s_valid = 1'b1;
                host.s_data  = (sent < N) ? K'(xb + sent) : K'(yb + sent - N);
            end
            acc = host.s_valid && host.s_ready;
            step();
            budget++;
            if (acc) sent++;
        end
        host.s_valid = 1'b0;
        check("load_complete", K'(sent), K'(2 * N));
    endtask

    // Entered one cycle after the last accept; leaves on the first cycle after the stream.
    task automatic check_stream(input int xb, input int yb);
        check("start_pulse", me_start, 1'b1);
        for (int g = 0; g < G; g++) begin
            step();
            check("gap_quiet", {me_start, me_x_valid, me_y_valid}, '0);
        end
        for (int i = 0; i <= N; i++) begin
            step();
            check("beat_x_valid", me_x_valid, 1'b1);
            check("beat_y_valid", me_y_valid, 1'b1);
            check("beat_x", me_x, (i < N) ? K'(xb + i) : '0);
            check("beat_y", me_y, (i < N) ? K'(yb + i) : '0);
        end
        step();
        check("stream_end", {me_x_valid, me_y_valid}, '0);
    endtask

    task automatic result(input int delay);
        int off   = -1;
        int ndone = 0;
        repeat (delay) step();
        me_valid = 1'b1;
        for (int k = 0; k < N + 4; k++) begin
            if (job_done) begin
                if (off < 0) off = k;
                ndone++;
            end
            if (k == N) begin
                check("ready_after_done", host.s_ready, 1'b1);
                check("idle_after_done", busy, 1'b0);
            end
            step();
            me_valid = 1'b0;
        end
        check("done_offset", K'(off), K'(N - 1));
        check("done_width", K'(ndone), K'(1));
    endtask

    task automatic spurious_valid();
        me_valid = 1'b1;
        step();
        me_valid = 1'b0;
        step();
        check("spurious_busy", busy, 1'b0);
        check("spurious_ready", host.s_ready, 1'b1);
    endtask

    initial begin
        int errs  = 0;
        int holds = 0;
        int eoff  = -1;
        int ndone = 0;
        host.s_valid = 1'b0;
        host.s_data  = '0;
        // reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("reset_s_ready", host.s_ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_outputs", {me_start, me_x_valid, me_y_valid, job_done, err}, '0);
        check("reset_state", state_dbg, ST_LOAD);
        step();
        check("ready_after_reset", host.s_ready, 1'b1);
        spurious_valid();

        // nominal job
        load_job(1, 'h100, 1'b0);
        check_stream(1, 'h100);
        result(50);
        spurious_valid();

        // host backpressure, same operands
        load_job(1, 'h100, 1'b1);
        check_stream(1, 'h100);
        result(20);

        // back-to-back, only Y changes
        load_job(1, 'h200, 1'b0);
        check_stream(1, 'h200);
        result(10);

        // reset in the middle of the stream at beat 5
        load_job('h500, 'h600, 1'b0);
        repeat (G + 6) step();
        check("beat5_x", me_x, K'('h505));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valids", {me_x_valid, me_y_valid}, '0);
        check("abort_busy", busy, 1'b0);
        step();
        check("abort_ready", host.s_ready, 1'b1);
        load_job('h300, 'h400, 1'b0);
        check_stream('h300, 'h400);
        result(5);

        // no result from the core
        load_job(7, 'h700, 1'b0);
        check_stream(7, 'h700);
`ifdef ME_LOADER_TIMEOUT_EN
        for (int k = 0; k < TO + 3; k++) begin
            if (err && (eoff < 0)) eoff = k;
            if (job_done) ndone++;
            if (k == TO) check("ready_after_timeout", host.s_ready, 1'b1);
            step();
        end
        check("err_offset", K'(eoff), K'(TO - 1));
        check("no_done_on_timeout", K'(ndone), '0);
`else
        for (int k = 0; k < 150; k++) begin
            if (err) errs++;
            if (busy) holds++;
            step();
        end
        check("err_quiet", K'(errs), '0);
        check("busy_held", K'(holds), K'(150));
        check("no_done_unresolved", K'(ndone + eoff + 1), '0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit cycle %0d: got timeout expected completion", cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
